// File: rtl/accum_feed_ctrl.sv
// rtl/accum_feed_ctrl.sv - job sequencer that feeds a product stream into an accumulator
// and returns the rounded result.
module accum_feed_ctrl #(
  parameter int DATA_IN   = 16,
  parameter int OUT_W     = 32,
  parameter int CNT_W     = 10,
  parameter int MAX_BEATS = 1023,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         cfg_rnd_mode,
  input  logic [5:0]         cfg_shift_amt,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic [DATA_IN-1:0] s_data,
  output logic               acc_clr,
  output logic               acc_in_valid,
  output logic [DATA_IN-1:0] acc_addend,
  output logic [1:0]         acc_rnd_mode,
  output logic [5:0]         acc_shift_amt,
  output logic               acc_commit,
  input  logic               acc_out_valid,
  input  logic [OUT_W-1:0]   acc_out_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic [CNT_W-1:0]   m_count,
  output logic               m_trunc,
  output logic               m_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FEED   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;

  localparam int              TW      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_BEATS);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               trunc_q, trunc_d;
  logic [TW-1:0]      wait_q, wait_d;

  logic               s_ready_q, s_ready_d;
  logic               acc_clr_q, acc_clr_d;
  logic               acc_in_valid_q, acc_in_valid_d;
  logic [DATA_IN-1:0] acc_addend_q, acc_addend_d;
  logic [1:0]         acc_rnd_mode_q, acc_rnd_mode_d;
  logic [5:0]         acc_shift_amt_q, acc_shift_amt_d;
  logic               acc_commit_q, acc_commit_d;
  logic               m_valid_q, m_valid_d;
  logic [OUT_W-1:0]   m_data_q, m_data_d;
  logic [CNT_W-1:0]   m_count_q, m_count_d;
  logic               m_trunc_q, m_trunc_d;
  logic               m_err_q, m_err_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    trunc_d         = trunc_q;
    wait_d          = wait_q;
    s_ready_d       = s_ready_q;
    acc_clr_d       = 1'b0;
    acc_in_valid_d  = 1'b0;
    acc_addend_d    = acc_addend_q;
    acc_rnd_mode_d  = acc_rnd_mode_q;
    acc_shift_amt_d = acc_shift_amt_q;
    acc_commit_d    = 1'b0;
    m_valid_d       = m_valid_q;
    m_data_d        = m_data_q;
    m_count_d       = m_count_q;
    m_trunc_d       = m_trunc_q;
    m_err_d         = m_err_q;

    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          acc_rnd_mode_d  = (cfg_rnd_mode == 2'b11) ? 2'b00 : cfg_rnd_mode;
          acc_shift_amt_d = cfg_shift_amt;
          acc_clr_d       = 1'b1;
          m_trunc_d       = 1'b0;
          m_err_d         = 1'b0;
          state_d         = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d     = '0;
        trunc_d   = 1'b0;
        s_ready_d = 1'b1;
        state_d   = S_FEED;
      end
      S_FEED: begin
        if (s_valid && s_ready_q) begin
          acc_in_valid_d = 1'b1;
          acc_addend_d   = s_data;
          cnt_d          = cnt_inc;
          // A forced end leaves the rest of the packet stalled for the next job.
          if (s_last || (cnt_inc == MAX_C)) begin
            s_ready_d = 1'b0;
            trunc_d   = !s_last;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        acc_commit_d = 1'b1;
        state_d      = S_COMMIT;
      end
      S_COMMIT: begin
        wait_d  = TW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc_out_valid) begin
          m_data_d  = acc_out_data;
          m_count_d = cnt_q;
          m_trunc_d = trunc_q;
          m_err_d   = 1'b0;
          m_valid_d = 1'b1;
          state_d   = S_HOLD;
        end else if (wait_q == TO_LAST) begin
          m_data_d  = '0;
          m_count_d = cnt_q;
          m_trunc_d = trunc_q;
          m_err_d   = 1'b1;
          m_valid_d = 1'b1;
          state_d   = S_HOLD;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      trunc_q         <= 1'b0;
      wait_q          <= '0;
      s_ready_q       <= 1'b0;
      acc_clr_q       <= 1'b0;
      acc_in_valid_q  <= 1'b0;
      acc_addend_q    <= '0;
      acc_rnd_mode_q  <= 2'b00;
      acc_shift_amt_q <= '0;
      acc_commit_q    <= 1'b0;
      m_valid_q       <= 1'b0;
      m_data_q        <= '0;
      m_count_q       <= '0;
      m_trunc_q       <= 1'b0;
      m_err_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      trunc_q         <= trunc_d;
      wait_q          <= wait_d;
      s_ready_q       <= s_ready_d;
      acc_clr_q       <= acc_clr_d;
      acc_in_valid_q  <= acc_in_valid_d;
      acc_addend_q    <= acc_addend_d;
      acc_rnd_mode_q  <= acc_rnd_mode_d;
      acc_shift_amt_q <= acc_shift_amt_d;
      acc_commit_q    <= acc_commit_d;
      m_valid_q       <= m_valid_d;
      m_data_q        <= m_data_d;
      m_count_q       <= m_count_d;
      m_trunc_q       <= m_trunc_d;
      m_err_q         <= m_err_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign acc_clr       = acc_clr_q;
  assign acc_in_valid  = acc_in_valid_q;
  assign acc_addend    = acc_addend_q;
  assign acc_rnd_mode  = acc_rnd_mode_q;
  assign acc_shift_amt = acc_shift_amt_q;
  assign acc_commit    = acc_commit_q;
  assign m_valid       = m_valid_q;
  assign m_data        = m_data_q;
  assign m_count       = m_count_q;
  assign m_trunc       = m_trunc_q;
  assign m_err         = m_err_q;

endmodule
